// File: rtl/dcache_controller.sv
// dcache_controller: direct-mapped, write-back, write-allocate data cache.
// Hits complete combinationally; misses stall the pipeline while the victim
// line is written back (if dirty) and the requested line is refilled.
module dcache_controller #(
  parameter int INDEX_W = 5,
  parameter int TAG_W   = 22
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [31:0]  cpu_addr_i,
  input  logic [31:0]  cpu_data_i,
  input  logic         cpu_memrd_i,
  input  logic         cpu_memwr_i,
  output logic [31:0]  cpu_data_o,
  output logic         cpu_stall_o,
  output logic [31:0]  mem_addr_o,
  output logic [255:0] mem_data_o,
  output logic         mem_enable_o,
  output logic         mem_write_o,
  input  logic [255:0] mem_data_i,
  input  logic         mem_ack_i
);

  localparam int LINES = 1 << INDEX_W;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_MISS      = 3'd1,
    S_WRITEBACK = 3'd2,
    S_READMISS  = 3'd3,
    S_REFILLED  = 3'd4
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // Line storage: valid/dirty need reset, tag/data arrays do not.
  logic [LINES-1:0] r_valid;
  logic [LINES-1:0] r_dirty;
  logic [TAG_W-1:0] r_tag  [LINES];
  logic [255:0]     r_data [LINES];

  logic [INDEX_W-1:0] w_idx;
  logic [TAG_W-1:0]   w_tag;
  logic [2:0]         w_word;
  logic [TAG_W-1:0]   w_vtag;
  logic [255:0]       w_line;
  logic [255:0]       w_store_line;
  logic [31:0]        w_word_data;
  logic               w_req;
  logic               w_hit;
  logic               w_idle;
  logic               w_wr_hit;
  logic               w_refill;
  logic               w_wb_done;
  logic               w_unused_addr_bits;

  assign w_idx  = cpu_addr_i[4+INDEX_W:5];
  assign w_tag  = cpu_addr_i[31:5+INDEX_W];
  assign w_word = cpu_addr_i[4:2];
  assign w_unused_addr_bits = ^cpu_addr_i[1:0];

  assign w_vtag      = r_tag[w_idx];
  assign w_line      = r_data[w_idx];
  assign w_word_data = w_line[w_word*32 +: 32];

  assign w_req     = cpu_memrd_i | cpu_memwr_i;
  assign w_hit     = r_valid[w_idx] & (w_vtag == w_tag);
  assign w_idle    = (r_state == S_IDLE);
  assign w_wr_hit  = w_idle & cpu_memwr_i & w_hit;
  assign w_refill  = (r_state == S_READMISS) & mem_ack_i;
  assign w_wb_done = (r_state == S_WRITEBACK) & mem_ack_i;

  // Current line with the addressed word replaced by the store data.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_store_merge
      assign w_store_line[gi*32 +: 32] = (w_word == 3'(gi)) ? cpu_data_i : w_line[gi*32 +: 32];
    end
  endgenerate

  // State register; reset abandons any transfer in flight.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic for the miss handling sequence.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:      if (w_req && !w_hit) w_state_next = S_MISS;
      S_MISS:      w_state_next = (r_valid[w_idx] && r_dirty[w_idx]) ? S_WRITEBACK : S_READMISS;
      S_WRITEBACK: if (mem_ack_i) w_state_next = S_MISS;
      S_READMISS:  if (mem_ack_i) w_state_next = S_REFILLED;
      S_REFILLED:  w_state_next = S_IDLE;
      default:     w_state_next = S_IDLE;
    endcase
  end

  // Output logic: memory port by state, CPU side gated off during reset.
  always_comb begin
    mem_enable_o = 1'b0;
    mem_write_o  = 1'b0;
    mem_addr_o   = 32'd0;
    mem_data_o   = 256'd0;
    case (r_state)
      S_WRITEBACK: begin
        mem_enable_o = 1'b1;
        mem_write_o  = 1'b1;
        mem_addr_o   = {w_vtag, w_idx, 5'b0};
        mem_data_o   = w_line;
      end
      S_READMISS: begin
        mem_enable_o = 1'b1;
        mem_addr_o   = {w_tag, w_idx, 5'b0};
      end
      default: ;
    endcase
    cpu_stall_o = rst_i & (!w_idle | (w_req & !w_hit));
    cpu_data_o  = (rst_i && w_idle && cpu_memrd_i && w_hit) ? w_word_data : 32'd0;
  end

  // Valid/dirty bookkeeping: refill, completed write-back, store hit.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else if (w_refill) begin
      r_valid[w_idx] <= 1'b1;
      r_dirty[w_idx] <= 1'b0;
    end else if (w_wb_done) begin
      r_dirty[w_idx] <= 1'b0;
    end else if (w_wr_hit) begin
      r_dirty[w_idx] <= 1'b1;
    end
  end

  // Tag and data arrays: whole-line refill or single-word store.
  always_ff @(posedge clk_i) begin
    if (w_refill) begin
      r_tag[w_idx]  <= w_tag;
      r_data[w_idx] <= mem_data_i;
    end else if (w_wr_hit) begin
      r_data[w_idx] <= w_store_line;
    end
  end

endmodule

// File: tb/tb_dcache_controller.sv
// Directed bench for dcache_controller: a line-level cache/memory model builds
// the expected per-cycle outputs for each access; one compare process checks
// them every cycle, and literal values pin the model at key points.
module tb_dcache_controller;

  logic         clk = 1'b0;
  logic         rst_i;
  logic [31:0]  cpu_addr_i;
  logic [31:0]  cpu_data_i;
  logic         cpu_memrd_i;
  logic         cpu_memwr_i;
  logic [31:0]  cpu_data_o;
  logic         cpu_stall_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o;
  logic         mem_enable_o;
  logic         mem_write_o;
  logic [255:0] mem_data_i;
  logic         mem_ack_i;

  always #5 clk = ~clk;

  dcache_controller dut (
    .clk_i(clk), .rst_i(rst_i),
    .cpu_addr_i(cpu_addr_i), .cpu_data_i(cpu_data_i),
    .cpu_memrd_i(cpu_memrd_i), .cpu_memwr_i(cpu_memwr_i),
    .cpu_data_o(cpu_data_o), .cpu_stall_o(cpu_stall_o),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
    .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o),
    .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i)
  );

  typedef struct {
    bit         rd;
    bit         wr;
    bit [31:0]  addr;
    bit [31:0]  wdat;
    bit         ack;
    bit [255:0] mdata;
    bit         e_stall;
    bit         e_en;
    bit         e_wr;
    bit [31:0]  e_addr;
    bit [255:0] e_line;
    bit         e_chkd;
    bit [31:0]  e_rdata;
  } rec_t;

  // Model of the cache contents and of the backing memory.
  bit         m_valid [32];
  bit         m_dirty [32];
  bit [21:0]  m_tag   [32];
  bit [255:0] m_line  [32];
  bit [255:0] mem_store [bit [31:0]];

  rec_t plan [$];
  rec_t exp_cur;
  bit   exp_on = 1'b0;

  int errors = 0;
  int checks = 0;

  int         st_cnt;
  int         en_cnt;
  bit [31:0]  wb_addr;
  bit [255:0] wb_line;
  bit [31:0]  rd_addr;
  bit [31:0]  last_rdata;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Untouched memory lines hold 0x1000_0000 + byte address of each word.
  function automatic bit [255:0] mem_read(input bit [31:0] la);
    bit [255:0] r;
    if (mem_store.exists(la)) return mem_store[la];
    for (int w = 0; w < 8; w++) r[w*32 +: 32] = 32'h1000_0000 + la + 32'(w * 4);
    return r;
  endfunction

  function automatic rec_t mk(input bit rd, input bit wr, input bit [31:0] addr, input bit [31:0] wdat);
    rec_t r;
    r = '{default: 0};
    r.rd = rd; r.wr = wr; r.addr = addr; r.wdat = wdat;
    r.e_chkd = 1'b1;
    return r;
  endfunction

  // Expand one CPU access into its expected cycle sequence and update the model.
  task automatic build(input bit rd, input bit wr, input bit [31:0] addr, input bit [31:0] wdat,
                       input int lwb, input int lrd);
    rec_t r;
    bit [4:0] idx;
    bit [21:0] t;
    int w;
    bit [31:0] la;
    bit [255:0] ln;
    idx = addr[9:5];
    t   = addr[31:10];
    w   = int'(addr[4:2]);
    if (rd || wr) begin
      if (!(m_valid[idx] && m_tag[idx] == t)) begin
        r = mk(rd, wr, addr, wdat);
        r.e_stall = 1'b1;
        plan.push_back(r);      // request seen, miss detected
        plan.push_back(r);      // MISS
        if (m_valid[idx] && m_dirty[idx]) begin
          la = {m_tag[idx], idx, 5'b0};
          for (int i = 0; i < lwb; i++) begin
            r = mk(rd, wr, addr, wdat);
            r.e_stall = 1'b1; r.e_en = 1'b1; r.e_wr = 1'b1;
            r.e_addr = la; r.e_line = m_line[idx];
            r.ack = (i == lwb - 1);
            plan.push_back(r);
          end
          mem_store[la] = m_line[idx];
          m_dirty[idx] = 1'b0;
          r = mk(rd, wr, addr, wdat);
          r.e_stall = 1'b1;
          plan.push_back(r);    // second MISS after the write-back
        end
        la = {t, idx, 5'b0};
        ln = mem_read(la);
        for (int i = 0; i < lrd; i++) begin
          r = mk(rd, wr, addr, wdat);
          r.e_stall = 1'b1; r.e_en = 1'b1; r.e_addr = la;
          r.ack = (i == lrd - 1);
          r.mdata = r.ack ? ln : ~ln;
          plan.push_back(r);
        end
        m_valid[idx] = 1'b1; m_tag[idx] = t; m_line[idx] = ln; m_dirty[idx] = 1'b0;
        r = mk(rd, wr, addr, wdat);
        r.e_stall = 1'b1;
        plan.push_back(r);      // REFILLED
      end
      r = mk(rd, wr, addr, wdat);
      if (wr) r.e_chkd = 1'b0;
      else    r.e_rdata = m_line[idx][w*32 +: 32];
      plan.push_back(r);
      if (wr) begin
        m_line[idx][w*32 +: 32] = wdat;
        m_dirty[idx] = 1'b1;
      end
    end else begin
      plan.push_back(mk(1'b0, 1'b0, addr, wdat));
    end
  endtask

  task automatic run_one(input rec_t r);
    @(posedge clk); #1;
    cpu_memrd_i = r.rd; cpu_memwr_i = r.wr;
    cpu_addr_i  = r.addr; cpu_data_i = r.wdat;
    mem_ack_i   = r.ack; mem_data_i = r.mdata;
    exp_cur = r;
    exp_on  = 1'b1;
    @(negedge clk); #1;
    if (cpu_stall_o) st_cnt++;
    if (mem_enable_o) begin
      en_cnt++;
      if (mem_write_o) begin wb_addr = mem_addr_o; wb_line = mem_data_o; end
      else rd_addr = mem_addr_o;
    end
    if (!cpu_stall_o) last_rdata = cpu_data_o;
  endtask

  task automatic run_plan();
    while (plan.size() > 0) run_one(plan.pop_front());
    exp_on = 1'b0;
  endtask

  task automatic access(input bit rd, input bit wr, input bit [31:0] addr, input bit [31:0] wdat,
                        input int lwb, input int lrd);
    st_cnt = 0; en_cnt = 0; wb_addr = 0; wb_line = 0; rd_addr = 0; last_rdata = 0;
    build(rd, wr, addr, wdat, lwb, lrd);
    run_plan();
    $display("txn rd=%0d wr=%0d addr=%08h data=%08h stall_cycles=%0d mem_cycles=%0d rdata=%08h",
             rd, wr, addr, wdat, st_cnt, en_cnt, last_rdata);
  endtask

  // Per-cycle comparison against the model's expected record.
  always @(negedge clk) begin
    if (exp_on) begin
      chk("stall", cpu_stall_o, exp_cur.e_stall);
      chk("mem_enable", mem_enable_o, exp_cur.e_en);
      if (exp_cur.e_en) begin
        chk("mem_write", mem_write_o, exp_cur.e_wr);
        chk("mem_addr", mem_addr_o, exp_cur.e_addr);
        if (exp_cur.e_wr) chk("mem_data", mem_data_o, exp_cur.e_line);
      end
      if (exp_cur.e_chkd) chk("cpu_data", cpu_data_o, exp_cur.e_rdata);
    end
  end

  initial begin
    rec_t r;
    rst_i = 1'b0; cpu_addr_i = 32'h40; cpu_data_i = 0;
    cpu_memrd_i = 1'b1; cpu_memwr_i = 1'b0;
    mem_data_i = 0; mem_ack_i = 1'b0;

    // Reset holds every output low even with a pending load.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", cpu_stall_o, 1'b0);
    chk("rst_enable", mem_enable_o, 1'b0);
    chk("rst_write", mem_write_o, 1'b0);
    chk("rst_cpu_data", cpu_data_o, 32'd0);
    chk("rst_mem_addr", mem_addr_o, 32'd0);
    chk("rst_mem_data", mem_data_o, 256'd0);
    @(posedge clk); #1;
    cpu_memrd_i = 1'b0;
    rst_i = 1'b1;

    // Clean miss, ack on the 9th enabled cycle (10 cycles after the request).
    access(1, 0, 32'h0000_0040, 0, 0, 9);
    chk("load40_stall_cycles", st_cnt, 12);
    chk("load40_read_addr", rd_addr, 32'h40);
    chk("load40_rdata", last_rdata, 32'h1000_0040);

    access(1, 0, 32'h0000_0044, 0, 0, 0);
    chk("load44_stall_cycles", st_cnt, 0);
    chk("load44_rdata", last_rdata, 32'h1000_0044);

    access(0, 1, 32'h0000_0040, 32'hDEAD_BEEF, 0, 0);
    chk("store40_stall_cycles", st_cnt, 0);

    // Conflict miss on a dirty line: write-back, MISS, refill.
    access(1, 0, 32'h0000_0440, 0, 4, 3);
    chk("load440_stall_cycles", st_cnt, 11);
    chk("load440_wb_addr", wb_addr, 32'h40);
    chk("load440_wb_word0", wb_line[31:0], 32'hDEAD_BEEF);
    chk("load440_read_addr", rd_addr, 32'h440);
    chk("load440_rdata", last_rdata, 32'h1000_0440);

    access(1, 0, 32'h0000_0440, 0, 0, 0);
    chk("reload440_stall_cycles", st_cnt, 0);
    chk("reload440_mem_cycles", en_cnt, 0);
    chk("reload440_rdata", last_rdata, 32'h1000_0440);

    // Ack in the very first enabled cycle.
    access(1, 0, 32'h0000_0060, 0, 0, 1);
    chk("load60_stall_cycles", st_cnt, 4);
    chk("load60_rdata", last_rdata, 32'h1000_0060);

    // Stray ack while idle is ignored.
    r = mk(0, 0, 32'h0, 0);
    r.ack = 1'b1;
    run_one(r);
    run_one(mk(0, 0, 32'h0, 0));
    exp_on = 1'b0;

    // Reset in the middle of READMISS.
    build(1, 0, 32'h0000_0860, 0, 0, 5);
    for (int k = 0; k < 4; k++) run_one(plan.pop_front());
    plan.delete();
    exp_on = 1'b0;
    chk("mid_readmiss_enable", mem_enable_o, 1'b1);
    #1 rst_i = 1'b0;
    #1;
    chk("async_rst_enable", mem_enable_o, 1'b0);
    chk("async_rst_stall", cpu_stall_o, 1'b0);
    chk("async_rst_mem_addr", mem_addr_o, 32'd0);
    chk("async_rst_cpu_data", cpu_data_o, 32'd0);
    @(posedge clk); #1;
    cpu_memrd_i = 1'b0; mem_ack_i = 1'b0;
    rst_i = 1'b1;
    $display("txn reset during READMISS of addr=00000860");
    for (int i = 0; i < 32; i++) begin m_valid[i] = 1'b0; m_dirty[i] = 1'b0; end
    r = mk(0, 0, 32'h0, 0);
    r.ack = 1'b1;           // late ack after release
    run_one(r);
    run_one(mk(0, 0, 32'h0, 0));
    exp_on = 1'b0;

    access(1, 0, 32'h0000_0440, 0, 0, 2);
    chk("post_rst_load440_stall_cycles", st_cnt, 5);
    chk("post_rst_load440_rdata", last_rdata, 32'h1000_0440);

    // Load and store together on a hit: store wins, no traffic.
    access(1, 1, 32'h0000_0448, 32'h1234_5678, 0, 0);
    chk("rdwr_stall_cycles", st_cnt, 0);
    chk("rdwr_mem_cycles", en_cnt, 0);

    // Evicting that line proves the store landed and marked it dirty.
    access(1, 0, 32'h0000_0040, 0, 2, 2);
    chk("evict_stall_cycles", st_cnt, 8);
    chk("evict_wb_addr", wb_addr, 32'h440);
    chk("evict_wb_word2", wb_line[95:64], 32'h1234_5678);
    chk("evict_wb_word0", wb_line[31:0], 32'h1000_0440);
    chk("evict_rdata", last_rdata, 32'hDEAD_BEEF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
